// File: rtl/wb_write_queue.sv
// Writeback queue in front of the 8x16 register file: buffers results, drains one per granted cycle, forwards pending data.
// Optional `WB_REG0_HARDWIRE_EN: register 0 reads as zero and dest-0 writes are acknowledged but dropped.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [2:0]       wb_dest,
    input  logic [15:0]      wb_data,
    input  logic             drain_en,
    output logic             reg_write_en,
    output logic [2:0]       reg_write_dest,
    output logic [15:0]      reg_write_data,
    input  logic [2:0]       reg_read_addr_1,
    input  logic [15:0]      rf_read_data_1,
    output logic [15:0]      fwd_read_data_1,
    input  logic [2:0]       reg_read_addr_2,
    input  logic [15:0]      rf_read_data_2,
    output logic [15:0]      fwd_read_data_2,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]       mem_dest [DEPTH];
    logic [15:0]      mem_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             push;
    logic             pop;
    logic             hit_1;
    logic             hit_2;
    logic [15:0]      hit_data_1;
    logic [15:0]      hit_data_2;
    logic [PTR_W-1:0] idx;

    // Status comes from the count register only.
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign wb_ready = !full;
    assign count    = cnt;

    assign accept = wb_valid && wb_ready;
`ifdef WB_REG0_HARDWIRE_EN
    assign push   = accept && (wb_dest != 3'd0);
`else
    assign push   = accept;
`endif
    assign pop    = drain_en && !empty;

    // Head entry is presented combinationally to the register file write port.
    assign reg_write_en   = pop;
    assign reg_write_dest = empty ? 3'd0  : mem_dest[rd_ptr];
    assign reg_write_data = empty ? 16'd0 : mem_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_dest[i] <= '0;
                mem_data[i] <= '0;
            end
        end else if (push) begin
            mem_dest[wr_ptr] <= wb_dest;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        hit_1      = 1'b0;
        hit_2      = 1'b0;
        hit_data_1 = '0;
        hit_data_2 = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < cnt) begin
                if (mem_dest[idx] == reg_read_addr_1) begin
                    hit_1      = 1'b1;
                    hit_data_1 = mem_data[idx];
                end
                if (mem_dest[idx] == reg_read_addr_2) begin
                    hit_2      = 1'b1;
                    hit_data_2 = mem_data[idx];
                end
            end
        end
    end

`ifdef WB_REG0_HARDWIRE_EN
    assign fwd_read_data_1 = (reg_read_addr_1 == 3'd0) ? 16'h0000 :
                             hit_1 ? hit_data_1 : rf_read_data_1;
    assign fwd_read_data_2 = (reg_read_addr_2 == 3'd0) ? 16'h0000 :
                             hit_2 ? hit_data_2 : rf_read_data_2;
`else
    assign fwd_read_data_1 = hit_1 ? hit_data_1 : rf_read_data_1;
    assign fwd_read_data_2 = hit_2 ? hit_data_2 : rf_read_data_2;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_valid;
    logic             wb_ready;
    logic [2:0]       wb_dest;
    logic [15:0]      wb_data;
    logic             drain_en;
    logic             reg_write_en;
    logic [2:0]       reg_write_dest;
    logic [15:0]      reg_write_data;
    logic [2:0]       reg_read_addr_1;
    logic [15:0]      rf_read_data_1;
    logic [15:0]      fwd_read_data_1;
    logic [2:0]       reg_read_addr_2;
    logic [15:0]      rf_read_data_2;
    logic [15:0]      fwd_read_data_2;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    int n_cmp = 0;
    int n_err = 0;

    wb_write_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
        .drain_en(drain_en), .reg_write_en(reg_write_en),
        .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .reg_read_addr_1(reg_read_addr_1), .rf_read_data_1(rf_read_data_1),
        .fwd_read_data_1(fwd_read_data_1),
        .reg_read_addr_2(reg_read_addr_2), .rf_read_data_2(rf_read_data_2),
        .fwd_read_data_2(fwd_read_data_2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of pending {dest, data}, oldest at front.
    logic [18:0] q[$];

    function automatic logic [15:0] model_fwd(input logic [2:0] addr, input logic [15:0] rf);
        logic [15:0] r;
        r = rf;
        for (int i = 0; i < q.size(); i++)
            if (q[i][18:16] == addr) r = q[i][15:0];
`ifdef WB_REG0_HARDWIRE_EN
        if (addr == 3'd0) r = 16'h0000;
`endif
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            logic do_pop, do_push;
            do_pop  = drain_en && (q.size() > 0);
            do_push = wb_valid && (q.size() < DEPTH);
`ifdef WB_REG0_HARDWIRE_EN
            if (wb_dest == 3'd0) do_push = 1'b0;
`endif
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({wb_dest, wb_data});
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_full", 32'(full), 32'(q.size() == DEPTH));
        chk("m_ready", 32'(wb_ready), 32'(q.size() != DEPTH));
        chk("m_wen", 32'(reg_write_en), 32'(drain_en && q.size() > 0));
        chk("m_wdest", 32'(reg_write_dest), (q.size() > 0) ? 32'(q[0][18:16]) : 32'd0);
        chk("m_wdata", 32'(reg_write_data), (q.size() > 0) ? 32'(q[0][15:0]) : 32'd0);
        chk("m_fwd1", 32'(fwd_read_data_1), 32'(model_fwd(reg_read_addr_1, rf_read_data_1)));
        chk("m_fwd2", 32'(fwd_read_data_2), 32'(model_fwd(reg_read_addr_2, rf_read_data_2)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [2:0] d, input logic [15:0] v);
        wb_valid = 1'b1;
        wb_dest  = d;
        wb_data  = v;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  pd;
        logic [15:0] pv;
        rst = 1'b1;
        wb_valid = 1'b0; wb_dest = '0; wb_data = '0; drain_en = 1'b0;
        reg_read_addr_1 = 3'd0; rf_read_data_1 = 16'h0;
        reg_read_addr_2 = 3'd0; rf_read_data_2 = 16'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(wb_ready), 32'd1);
        chk("rst_wen", 32'(reg_write_en), 32'd0);
        tick();

        // Reset mid-operation
        push1(3'd1, 16'h0101); push1(3'd2, 16'h0202); push1(3'd3, 16'h0303);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_ready", 32'(wb_ready), 32'd1);
        tick();
        rst = 1'b0;
        drain_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("post_rst_wen", 32'(reg_write_en), 32'd0);
            tick();
        end
        drain_en = 1'b0;

        // Fill and full
        for (int k = 1; k <= 4; k++) push1(3'(k), 16'(k * 16'h1111));
        wb_valid = 1'b1; wb_dest = 3'd5; wb_data = 16'h5555;
        #1;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(wb_ready), 32'd0);
        tick();
        chk("fill_ignored_count", 32'(count), 32'd4);
        wb_valid = 1'b0;
        drain_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("drain_wen", 32'(reg_write_en), 32'd1);
            chk("drain_dest", 32'(reg_write_dest), 32'(k));
            chk("drain_data", 32'(reg_write_data), 32'(k * 16'h1111));
            tick();
        end
        drain_en = 1'b0;
        #1 chk("drain_empty", 32'(empty), 32'd1);

        // Forward youngest
        reg_read_addr_1 = 3'd5; rf_read_data_1 = 16'h0000;
        push1(3'd5, 16'hAAAA); push1(3'd5, 16'hBBBB);
        #1 chk("fwd_young", 32'(fwd_read_data_1), 32'hBBBB);
        drain_en = 1'b1;
        tick();
        chk("fwd_after1", 32'(fwd_read_data_1), 32'hBBBB);
        tick();
        drain_en = 1'b0;
        rf_read_data_1 = 16'h7777;
        #1 chk("fwd_after2", 32'(fwd_read_data_1), 32'h7777);

        // Simultaneous push/pop with pointer wrap
        push1(3'd1, 16'h0100);
        pd = 3'd1; pv = 16'h0100;
        wb_valid = 1'b1; drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_dest = 3'((i % 7) + 1);
            wb_data = 16'(16'h0200 + i);
            #1;
            chk("pp_count", 32'(count), 32'd1);
            chk("pp_dest", 32'(reg_write_dest), 32'(pd));
            chk("pp_data", 32'(reg_write_data), 32'(pv));
            pd = wb_dest; pv = wb_data;
            tick();
        end
        wb_valid = 1'b0;
        tick();
        drain_en = 1'b0;
        #1 chk("pp_empty", 32'(empty), 32'd1);

        // Miss path and same-cycle enqueue invisibility
        reg_read_addr_2 = 3'd3; rf_read_data_2 = 16'h1234;
        #1 chk("miss", 32'(fwd_read_data_2), 32'h1234);
        wb_valid = 1'b1; wb_dest = 3'd3; wb_data = 16'h9999;
        #1 chk("miss_same_cycle", 32'(fwd_read_data_2), 32'h1234);
        tick();
        wb_valid = 1'b0;
        #1 chk("miss_next_cycle", 32'(fwd_read_data_2), 32'h9999);
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;

        // Register 0 behaviour
        reg_read_addr_1 = 3'd0; rf_read_data_1 = 16'h5555;
        push1(3'd0, 16'hFFFF);
        #1;
`ifdef WB_REG0_HARDWIRE_EN
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_fwd", 32'(fwd_read_data_1), 32'h0000);
        drain_en = 1'b1;
        #1 chk("r0_wen", 32'(reg_write_en), 32'd0);
`else
        chk("r0_count", 32'(count), 32'd1);
        chk("r0_fwd", 32'(fwd_read_data_1), 32'hFFFF);
        drain_en = 1'b1;
        #1 chk("r0_wen", 32'(reg_write_en), 32'd1);
`endif
        tick();
        drain_en = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writer-side companion to the 8x16 register file.
- Accepts writeback results from the pipeline through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the register file write port (reg_write_en/dest/data) whenever that port is granted.
- Forwards still-pending data to both read ports, so readers never see stale register contents.

Parameters:
DEPTH, 4, number of pending-write entries; power of two, >= 2
CNT_W, 3, width of count output; must equal clog2(DEPTH+1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
wb_valid  input  1  writeback request valid
wb_ready  output  1  queue can accept (= !full)
wb_dest  input  3  destination register index
wb_data  input  16  data to write
drain_en  input  1  register file write port granted this cycle
reg_write_en  output  1  to register file write enable
reg_write_dest  output  3  to register file write address
reg_write_data  output  16  to register file write data
reg_read_addr_1  input  3  read port 1 address (shared with register file)
rf_read_data_1  input  16  register file read data, port 1
fwd_read_data_1  output  16  forwarded read data, port 1
reg_read_addr_2  input  3  read port 2 address
rf_read_data_2  input  16  register file read data, port 2
fwd_read_data_2  output  16  forwarded read data, port 2
count  output  CNT_W  number of pending entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Storage: circular FIFO of {dest[2:0], data[15:0]} with write pointer, read pointer and count registers, all cleared by rst.
- Reset (async, any time, including mid-drain): all pending entries discarded, pointers = 0, count = 0.
- Reset output values: empty = 1, full = 0, wb_ready = 1, reg_write_en = 0. fwd_read_data_x = rf_read_data_x (pass-through).
- Enqueue: on a rising edge with wb_valid && wb_ready, {wb_dest, wb_data} is written at the write pointer and the write pointer advances, wrapping DEPTH-1 -> 0.
- When full, wb_valid is ignored and nothing is written; the producer must hold its request.
- Drain (combinational head presentation):
  - reg_write_en = drain_en && !empty.
  - reg_write_dest/data = head entry; these are 0 when empty.
  - On the same edge the register file captures the write, the head is popped and the read pointer advances with wrap.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- When full, enqueue and pop cannot happen together, because wb_ready = 0; the pop proceeds alone.
- count/empty/full are derived from the count register only; they are never combinational on wb_valid or drain_en.
- Forwarding, port x (combinational, zero latency):
  - Compare reg_read_addr_x against every valid entry.
  - If any match, fwd_read_data_x = data of the youngest matching entry (closest to the write pointer).
  - Otherwise fwd_read_data_x = rf_read_data_x.
- Duplicate destinations in the queue are legal; youngest wins.
- The head entry being drained this cycle still forwards; after the edge it is in the register file.
- The incoming wb_data in the enqueue cycle is NOT forwarded; it becomes visible the cycle after acceptance.
- Ordering: writes reach the register file strictly in acceptance order. No coalescing, no dropping, except under the optional feature below.

Optional Feature:
- Macro: WB_REG0_HARDWIRE_EN.
- Defined:
  - Register 0 reads as constant zero.
  - An accepted request with wb_dest == 0 is acknowledged (wb_ready honoured) but not enqueued; count is unchanged.
  - fwd_read_data_x = 16'h0000 whenever reg_read_addr_x == 0, regardless of rf_read_data_x.
- Undefined:
  - Register 0 is an ordinary register.
  - Dest-0 writes are queued and forwarded like any other index.

Test Plan:
- Reset mid-operation: enqueue 3 entries with drain_en = 0, then assert rst asynchronously between edges. Required: count = 0, empty = 1, wb_ready = 1 immediately; no reg_write_en pulse after release.
- Fill and full: with drain_en = 0, enqueue dest 1..4, data 16'h1111..16'h4444. Required: full = 1, wb_ready = 0; a 5th wb_valid is ignored; then drain_en = 1 for 4 cycles. Required: writes dest 1, 2, 3, 4 in order with matching data; then empty = 1.
- Forward youngest: queue (dest 5, 16'hAAAA) then (dest 5, 16'hBBBB), with rf_read_data_1 = 16'h0000 and reg_read_addr_1 = 5. Required: fwd_read_data_1 = 16'hBBBB. After the first drain it is still 16'hBBBB; after the second drain it passes through rf data.
- Simultaneous push/pop with pointer wrap: hold wb_valid = 1 and drain_en = 1 for 10 cycles with DEPTH = 4, starting with 1 entry queued. Required: count stays 1, pointers wrap, write sequence equals input sequence delayed by one.
- Miss path: queue empty, reg_read_addr_2 = 3, rf_read_data_2 = 16'h1234. Required: fwd_read_data_2 = 16'h1234. Same-cycle enqueue to dest 3 with 16'h9999: fwd_read_data_2 = 16'h1234 this cycle and 16'h9999 the next cycle.
- WB_REG0_HARDWIRE_EN defined: enqueue (dest 0, 16'hFFFF). Required: count stays 0, no reg_write_en, and fwd_read_data_1 for addr 0 = 16'h0000 with rf_read_data_1 = 16'h5555.
